// File: rtl/signed_divider.sv
`timescale 1ns/1ps
// signed_divider
//   Sequential signed integer divider. It uses a restoring shift/subtract loop
//   and produces one quotient bit per cycle. The quotient is truncated toward
//   zero, and the remainder takes the sign of the dividend (or is zero). It uses
//   the same start/valid handshake as the Booth multiplier.
//
//   Optional feature macro: SIGNED_DIVIDER_DIV_ZERO_EN
//     defined   : a zero divisor is detected at acceptance. CALC is skipped and
//                 the result arrives one edge later with div_by_zero=1.
//     undefined : there is no detection and div_by_zero is tied low. A zero
//                 divisor runs the full loop and yields Q=all ones, R=X.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        division request, honoured only while idle
//   X, Y         signed dividend / divisor, sampled on the accepting edge
//   Q, R         signed quotient / remainder, held until the next result
//   valid        one-cycle pulse when Q/R update
//   busy         high while an operation is in flight
//   overflow     -2^(N-1) / -1 flag, meaningful while valid is high
//   div_by_zero  zero-divisor flag, meaningful while valid is high
module signed_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         valid,
  output logic         busy,
  output logic         overflow,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, next_state;

  // The dividend magnitude shifts out of the top of this register.
  // Quotient bits shift into the bottom, so after N steps it holds |Q|.
  logic [N-1:0]  dividend;
  logic [N-1:0]  divisor;
  logic [N-1:0]  part_rem;
  logic [CW-1:0] count;
  logic          q_neg;
  logic          r_neg;
  logic          ovf_pend;
`ifdef SIGNED_DIVIDER_DIV_ZERO_EN
  logic          dz_pend;
`endif

  logic [N-1:0]  x_abs;
  logic [N-1:0]  y_abs;
  logic          y_zero;
  logic          is_ovf;
  logic [N:0]    shifted;
  logic          fits;

  // Operand magnitudes. Negating -2^(N-1) wraps back to 2^(N-1), and that
  // value is exactly right when read as an unsigned number.
  // The trial value needs N+1 bits. Once it passes the compare, the
  // difference is below the divisor and fits back into N bits.
  always_comb begin
    x_abs   = X[N-1] ? -X : X;
    y_abs   = Y[N-1] ? -Y : Y;
    y_zero  = (Y == '0);
    is_ovf  = (X == {1'b1, {(N-1){1'b0}}}) && (Y == '1);
    shifted = {part_rem, dividend[N-1]};
    fits    = (shifted >= {1'b0, divisor});
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef SIGNED_DIVIDER_DIV_ZERO_EN
          next_state = y_zero ? FIX : CALC;
`else
          next_state = CALC;
`endif
        end
      end
      CALC:    if (count == LAST) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath and registered outputs.
  // A zero divisor has no sign, so it never requests quotient negation. The
  // all-ones quotient magnitude is then reported unchanged as -1, whichever
  // path produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend <= '0;
      divisor  <= '0;
      part_rem <= '0;
      count    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      ovf_pend <= 1'b0;
      Q        <= '0;
      R        <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
`ifdef SIGNED_DIVIDER_DIV_ZERO_EN
      dz_pend     <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_neg    <= (X[N-1] ^ Y[N-1]) & ~y_zero;
            r_neg    <= X[N-1];
            dividend <= x_abs;
            divisor  <= y_abs;
            part_rem <= '0;
            count    <= '0;
            ovf_pend <= is_ovf;
`ifdef SIGNED_DIVIDER_DIV_ZERO_EN
            dz_pend  <= y_zero;
            if (y_zero) begin
              dividend <= '1;
              part_rem <= x_abs;
            end
`endif
          end
        end
        CALC: begin
          part_rem <= fits ? (shifted[N-1:0] - divisor) : shifted[N-1:0];
          dividend <= {dividend[N-2:0], fits};
          count    <= count + 1'b1;
        end
        FIX: begin
          Q        <= q_neg ? -dividend : dividend;
          R        <= r_neg ? -part_rem : part_rem;
          overflow <= ovf_pend;
          valid    <= 1'b1;
`ifdef SIGNED_DIVIDER_DIV_ZERO_EN
          div_by_zero <= dz_pend;
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef SIGNED_DIVIDER_DIV_ZERO_EN
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_signed_divider.sv
`timescale 1ns/1ps
// tb_signed_divider
//   Directed self-checking bench for signed_divider at N=8. It covers reset
//   state, the sign matrix, overflow, zero divisor, start ignored while busy,
//   and reset in the middle of an operation.
module tb_signed_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] X;
  logic [7:0] Y;
  logic [7:0] Q;
  logic [7:0] R;
  logic       valid;
  logic       busy;
  logic       overflow;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  signed_divider #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .X           (X),
    .Y           (Y),
    .Q           (Q),
    .R           (R),
    .valid       (valid),
    .busy        (busy),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Watchdog so a stuck design still terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it and report any difference
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present an operand pair for one accepting edge, then scramble the inputs
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    X     = x;
    Y     = y;
    @(posedge clk); #1;
    start = 1'b0;
    X     = 8'h5A;
    Y     = 8'hC3;
  endtask

  // Wait up to 30 edges for valid and count the edges where busy was low early
  task automatic waitValid(output int lat, output int busy_low);
    lat      = -1;
    busy_low = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = k;
        break;
      end
      if (!busy) busy_low++;
    end
  endtask

  // Full transaction: accept, wait, check every output, then check the valid drop
  task automatic runDivide(input string name, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] exp_q, input logic [7:0] exp_r,
                           input logic exp_ovf, input logic exp_dz, input int exp_lat);
    int lat;
    int busy_low;
    applyStimulus(x, y);
    checkOutput({name, "_busy_e0"}, busy, 1);
    waitValid(lat, busy_low);
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput({name, "_busy_gap"}, busy_low, 0);
    checkOutput({name, "_busy_done"}, busy, 0);
    checkOutput({name, "_q"}, Q, exp_q);
    checkOutput({name, "_r"}, R, exp_r);
    checkOutput({name, "_ovf"}, overflow, exp_ovf);
    checkOutput({name, "_dz"}, div_by_zero, exp_dz);
    @(posedge clk); #1;
    checkOutput({name, "_valid_drop"}, valid, 0);
    checkOutput({name, "_q_hold"}, Q, exp_q);
  endtask

  initial begin
    int lat;
    int nvalid;

    rst   = 1'b1;
    start = 1'b0;
    X     = 8'h00;
    Y     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_q", Q, 0);
    checkOutput("reset_r", R, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ovf", overflow, 0);
    checkOutput("reset_dz", div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic and sign matrix");
    runDivide("pp",  8'd100, 8'd7,  8'd14,  8'd2,  1'b0, 1'b0, 9);
    runDivide("np",  8'h9C,  8'd7,  8'hF2,  8'hFE, 1'b0, 1'b0, 9);
    runDivide("pn",  8'd100, 8'hF9, 8'hF2,  8'd2,  1'b0, 1'b0, 9);
    runDivide("nn",  8'h9C,  8'hF9, 8'd14,  8'hFE, 1'b0, 1'b0, 9);

    $display("[TB] overflow boundary");
    runDivide("ovf",   8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b0, 9);
    runDivide("noovf", 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 9);

    $display("[TB] zero divisor");
`ifdef SIGNED_DIVIDER_DIV_ZERO_EN
    runDivide("dz", 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b0, 1'b1, 1);
`else
    runDivide("dz", 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b0, 1'b0, 9);
`endif

    $display("[TB] start while busy is ignored");
    nvalid = 0;
    lat    = -1;
    applyStimulus(8'd50, 8'd5);
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) begin
        start = 1'b1;
        X     = 8'd9;
        Y     = 8'd2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (valid) begin
        nvalid++;
        if (lat < 0) begin
          lat = k;
          checkOutput("ign_q", Q, 10);
          checkOutput("ign_r", R, 0);
        end
      end
    end
    checkOutput("ign_latency", lat, 9);
    checkOutput("ign_valid_count", nvalid, 1);

    $display("[TB] reset mid-operation");
    nvalid = 0;
    applyStimulus(8'd100, 8'd7);
    repeat (4) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_q", Q, 0);
    checkOutput("rst_mid_r", R, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_valid", valid, 0);
    repeat (2) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    checkOutput("rst_mid_no_valid", nvalid, 0);
    runDivide("post_rst", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 1'b0, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
